store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: Depth, 4, number of buffered store entries (power of two).
REQ-002 Parameter: DepthLog2, 2, log2(Depth); pointer width.
REQ-003 One clock; reset is asynchronous and active-high; ports named clk and rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 mem_ce_i  input  1  MEM-stage memory access request.
REQ-007 mem_we_i  input  1  1 = store, 0 = load (valid when mem_ce_i=1).
REQ-008 mem_sel_i  input  4  byte lane enables; bit3 = data[31:24].
REQ-009 mem_addr_i  input  32  byte address; word index = addr[31:2].
REQ-010 mem_data_i  input  32  store data.
REQ-011 mem_data_o  output  32  load data returned to MEM stage.
REQ-012 stallreq_o  output  1  pipeline stall request (combinational).
REQ-013 empty_o  output  1  1 when no entries are buffered.
REQ-014 ram_ce_o, ram_we_o  output  1 each  data RAM chip and write enable.
REQ-015 ram_sel_o  output  4  data RAM byte enables.
REQ-016 ram_addr_o  output  32  data RAM address.
REQ-017 ram_data_o  output  32  data RAM write data.
REQ-018 ram_data_i  input  32  data RAM read data (combinational read, same cycle).

Function
REQ-019 Block SHALL hold a circular FIFO of Depth entries {addr[31:2], sel, data}, with head/tail pointers of DepthLog2 bits wrapping modulo Depth and a count of 0..Depth.
REQ-020 Store (ce=1, we=1, sel!=0) with count<Depth SHALL be enqueued at tail on the next rising edge, with stallreq_o=0.
REQ-021 Store with count==Depth SHALL drive stallreq_o=1 and SHALL NOT be enqueued; it is retried by the held pipeline.
REQ-022 Store with sel==0 SHALL be accepted without stall and SHALL NOT be enqueued.
REQ-023 Load (ce=1, we=0) whose addr[31:2] matches any valid entry SHALL drive stallreq_o=1 and mem_data_o=0; the RAM port drains the head that cycle.
REQ-024 Load with no match SHALL own the RAM port: ram_ce_o=1, ram_we_o=0, ram_addr_o=mem_addr_i, ram_sel_o=mem_sel_i, mem_data_o=ram_data_i, same cycle, stallreq_o=0; no drain that cycle.
REQ-025 In any cycle not owned by a load, if count>0 the block SHALL drive the head entry (ram_ce_o=1, ram_we_o=1, ram_addr_o={addr,2'b00}, ram_sel_o, ram_data_o) and pop it on the rising edge.
REQ-026 Simultaneous enqueue and pop SHALL leave count unchanged and advance both pointers.
REQ-027 Entries SHALL drain in strict FIFO order; a store presented in cycle k is written to RAM at the end of cycle k+1 at the earliest.
REQ-028 When ram_ce_o=0, ram_we_o, ram_sel_o, ram_addr_o and ram_data_o SHALL be 0; mem_data_o SHALL be 0 unless REQ-024 applies.
REQ-029 empty_o SHALL equal (count==0), registered-state derived.
REQ-030 Full-check for REQ-020/021 SHALL use count at cycle start; a pop in the same cycle SHALL NOT admit a store to a full buffer.

Reset
REQ-031 While rst=1: count, head, tail = 0, all entries invalid, stallreq_o=0, empty_o=1, all ram_* outputs and mem_data_o = 0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered stores immediately without writing them to RAM.

Verification
REQ-033 Single store addr=0x10, sel=4'hF, data=0xDEADBEEF, then idle -> cycle+1 ram_we_o=1, ram_addr_o=0x10, ram_data_o=0xDEADBEEF; empty_o=1 after that edge.
REQ-034 Five back-to-back stores, Depth=4, continuous loads elsewhere blocking drain -> 5th store sees stallreq_o=1 until one entry drains, then enqueues; RAM receives all five in order.
REQ-035 Store 0x20 data=0x11223344, next cycle load 0x20 -> stallreq_o=1 during drain, then load returns 0x11223344 with stallreq_o=0.
REQ-036 Buffered store to 0x40, load 0x44 -> no stall, ram_we_o=0 that cycle, store drains the following idle cycle.
REQ-037 Three stores buffered, assert rst for one cycle -> empty_o=1, no further RAM writes, later load of those addresses returns prior RAM contents.
REQ-038 Fill and drain 2*Depth+1 entries -> pointers wrap; RAM contents and order match a reference FIFO model.

Source files
------------

// File: rtl/store_buffer_if.sv
// Bundles the MEM-stage request/response and data-RAM port signals of the store buffer.
// The slave modport is the buffer itself; the master modport is the pipeline/RAM side.
interface store_buffer_if;
    logic        mem_ce_i;
    logic        mem_we_i;
    logic [3:0]  mem_sel_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        stallreq_o;
    logic        empty_o;
    logic        ram_ce_o;
    logic        ram_we_o;
    logic [3:0]  ram_sel_o;
    logic [31:0] ram_addr_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    modport slave (
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, ram_data_i,
        output mem_data_o, stallreq_o, empty_o,
        output ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o
    );

    modport master (
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i, ram_data_i,
        input  mem_data_o, stallreq_o, empty_o,
        input  ram_ce_o, ram_we_o, ram_sel_o, ram_addr_o, ram_data_o
    );
endinterface

// File: rtl/store_buffer.sv
// Circular store buffer between the MEM stage and a single-ported data RAM.
// Stores are queued and drained in FIFO order whenever a load does not own the RAM port.
module store_buffer #(
    parameter int Depth     = 4,
    parameter int DepthLog2 = 2
) (
    input logic          clk,
    input logic          rst,
    store_buffer_if.slave sb
);

    logic [29:0]      r_addr  [Depth];
    logic [3:0]       r_sel   [Depth];
    logic [31:0]      r_data  [Depth];
    logic [Depth-1:0] r_valid;
    logic [DepthLog2-1:0] r_head;
    logic [DepthLog2-1:0] r_tail;
    logic [DepthLog2:0]   r_count;

    logic w_isStore;
    logic w_isLoad;
    logic w_hit;
    logic w_loadOwns;
    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_isStore  = sb.mem_ce_i & sb.mem_we_i;
    assign w_isLoad   = sb.mem_ce_i & ~sb.mem_we_i;
    assign w_full     = (r_count == DepthLog2'(0) + (DepthLog2+1)'(Depth));
    assign w_loadOwns = w_isLoad & ~w_hit;
    assign w_push     = w_isStore & (sb.mem_sel_i != 4'b0000) & ~w_full;
    assign w_pop      = ~w_loadOwns & (r_count != '0);

    // A load that aliases any buffered word must wait for the buffer to drain past it.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 0; i < Depth; i++) begin
            if (w_isLoad && r_valid[i] && (r_addr[i] == sb.mem_addr_i[31:2])) begin
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        sb.ram_ce_o   = 1'b0;
        sb.ram_we_o   = 1'b0;
        sb.ram_sel_o  = 4'b0000;
        sb.ram_addr_o = 32'h0;
        sb.ram_data_o = 32'h0;
        sb.mem_data_o = 32'h0;
        sb.stallreq_o = 1'b0;
        if (!rst) begin
            sb.stallreq_o = w_hit | (w_isStore & (sb.mem_sel_i != 4'b0000) & w_full);
            if (w_loadOwns) begin
                sb.ram_ce_o   = 1'b1;
                sb.ram_sel_o  = sb.mem_sel_i;
                sb.ram_addr_o = sb.mem_addr_i;
                sb.mem_data_o = sb.ram_data_i;
            end else if (w_pop) begin
                sb.ram_ce_o   = 1'b1;
                sb.ram_we_o   = 1'b1;
                sb.ram_sel_o  = r_sel[r_head];
                sb.ram_addr_o = {r_addr[r_head], 2'b00};
                sb.ram_data_o = r_data[r_head];
            end
        end
    end

    assign sb.empty_o = (r_count == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (w_pop) begin
                r_valid[r_head] <= 1'b0;
                r_head          <= r_head + 1'b1;
            end
            if (w_push) begin
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; r_valid and r_count decide what is live.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_addr[r_tail] <= sb.mem_addr_i[31:2];
            r_sel[r_tail]  <= sb.mem_sel_i;
            r_data[r_tail] <= sb.mem_data_i;
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios then random traffic,
// each cycle compared against a queue-based model of pending stores and RAM contents.
module tb_store_buffer;

    typedef struct {
        logic [29:0] a;
        logic [3:0]  s;
        logic [31:0] d;
    } entry_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic [31:0] ramMem [0:255];
    logic [31:0] refMem [0:255];
    entry_t      pending [$];

    store_buffer_if sif ();

    store_buffer #(.Depth(4), .DepthLog2(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sif.slave)
    );

    always #5 clk = ~clk;

    // Behavioural data RAM: combinational read, byte-masked write on the rising edge.
    assign sif.ram_data_i = ramMem[sif.ram_addr_o[9:2]];

    always @(posedge clk) begin
        if (sif.ram_ce_o && sif.ram_we_o) begin
            for (int b = 0; b < 4; b++) begin
                if (sif.ram_sel_o[b]) ramMem[sif.ram_addr_o[9:2]][8*b +: 8] <= sif.ram_data_o[8*b +: 8];
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One MEM-stage cycle: drive request, compare all outputs with the model, then advance.
    task automatic applyStimulus(input logic ce, input logic we, input logic [3:0] sel,
                                 input logic [31:0] addr, input logic [31:0] data);
        int     size;
        logic   isSt, isLd, hit, ldOwn, full, doPush, doPop;
        logic   eCe, eWe;
        logic [3:0]  eSel;
        logic [31:0] eAddr, eData, eMem;
        entry_t      e;
        sif.mem_ce_i   = ce;
        sif.mem_we_i   = we;
        sif.mem_sel_i  = sel;
        sif.mem_addr_i = addr;
        sif.mem_data_i = data;
        size  = pending.size();
        isSt  = ce & we;
        isLd  = ce & ~we;
        hit   = 1'b0;
        foreach (pending[i]) if (isLd && pending[i].a == addr[31:2]) hit = 1'b1;
        ldOwn  = isLd & ~hit;
        full   = (size == 4);
        doPush = isSt && (sel != 0) && !full;
        doPop  = !ldOwn && (size > 0);
        eCe = 0; eWe = 0; eSel = 0; eAddr = 0; eData = 0; eMem = 0;
        if (ldOwn) begin
            eCe = 1; eSel = sel; eAddr = addr; eMem = refMem[addr[9:2]];
        end else if (doPop) begin
            eCe = 1; eWe = 1; eSel = pending[0].s; eAddr = {pending[0].a, 2'b00}; eData = pending[0].d;
        end
        #5;
        checkOutput("stallreq", 32'(sif.stallreq_o), 32'(hit || (isSt && sel != 0 && full)));
        checkOutput("empty",    32'(sif.empty_o),    32'(size == 0));
        checkOutput("ram_ce",   32'(sif.ram_ce_o),   32'(eCe));
        checkOutput("ram_we",   32'(sif.ram_we_o),   32'(eWe));
        checkOutput("ram_sel",  32'(sif.ram_sel_o),  32'(eSel));
        checkOutput("ram_addr", sif.ram_addr_o,      eAddr);
        checkOutput("ram_data", sif.ram_data_o,      eData);
        checkOutput("mem_data", sif.mem_data_o,      eMem);
        @(posedge clk);
        if (doPop) begin
            e = pending.pop_front();
            for (int b = 0; b < 4; b++) if (e.s[b]) refMem[e.a[7:0]][8*b +: 8] = e.d[8*b +: 8];
        end
        if (doPush) begin
            e.a = addr[31:2]; e.s = sel; e.d = data;
            pending.push_back(e);
        end
        #1;
    endtask

    task automatic applyReset();
        rst = 1'b1;
        #2;
        checkOutput("rst_empty",    32'(sif.empty_o),    32'd1);
        checkOutput("rst_stall",    32'(sif.stallreq_o), 32'd0);
        checkOutput("rst_ram_ce",   32'(sif.ram_ce_o),   32'd0);
        checkOutput("rst_ram_we",   32'(sif.ram_we_o),   32'd0);
        checkOutput("rst_ram_addr", sif.ram_addr_o,      32'd0);
        checkOutput("rst_ram_data", sif.ram_data_o,      32'd0);
        checkOutput("rst_mem_data", sif.mem_data_o,      32'd0);
        pending.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] rAddr;
        clk = 1'b0;
        rst = 1'b1;
        total = 0;
        bad = 0;
        sif.mem_ce_i = 0; sif.mem_we_i = 0; sif.mem_sel_i = 0;
        sif.mem_addr_i = 0; sif.mem_data_i = 0;
        for (int i = 0; i < 256; i++) begin
            ramMem[i] = 32'hA5A50000 ^ (i * 32'h00010203);
            refMem[i] = 32'hA5A50000 ^ (i * 32'h00010203);
        end
        applyReset();

        $display("[TB] single store then idle");
        applyStimulus(1, 1, 4'hF, 32'h10, 32'hDEADBEEF);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);

        $display("[TB] load aliasing a buffered store");
        applyStimulus(1, 1, 4'hF, 32'h20, 32'h11223344);
        applyStimulus(1, 0, 4'hF, 32'h20, 32'h0);
        applyStimulus(1, 0, 4'hF, 32'h20, 32'h0);

        $display("[TB] load to neighbouring word");
        applyStimulus(1, 1, 4'hF, 32'h40, 32'hCAFEF00D);
        applyStimulus(1, 0, 4'hF, 32'h44, 32'h0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
        applyStimulus(1, 0, 4'hF, 32'h40, 32'h0);

        $display("[TB] zero-sel store and partial byte store");
        applyStimulus(1, 1, 4'h0, 32'h30, 32'h99999999);
        applyStimulus(1, 1, 4'b0101, 32'h34, 32'h12345678);
        applyStimulus(1, 0, 4'hF, 32'h30, 32'h0);
        applyStimulus(1, 0, 4'hF, 32'h34, 32'h0);

        $display("[TB] reset discards a buffered store");
        applyStimulus(1, 1, 4'hF, 32'h38, 32'h0BADF00D);
        applyReset();
        applyStimulus(1, 0, 4'hF, 32'h38, 32'h0);
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);

        $display("[TB] pointer wrap with many stores");
        for (int i = 0; i < 9; i++) applyStimulus(1, 1, 4'hF, 32'h80 + 32'(i * 4), 32'h5000 + 32'(i));
        applyStimulus(0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 9; i++) applyStimulus(1, 0, 4'hF, 32'h80 + 32'(i * 4), 32'h0);

        $display("[TB] random traffic");
        for (int n = 0; n < 400; n++) begin
            rAddr = {22'h0, 4'($urandom_range(0, 15)), 2'b00, 2'($urandom)};
            if ($urandom_range(0, 60) == 0) applyReset();
            else applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                               rAddr, $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
